// File: rtl/i2s_audio_tx.sv
// I2S transmitter for the Pmod DAC. One 9-bit counter drives MCLK/SCK/LRCK, and a 32-bit shift register holds each frame.
// Define SOFT_MUTE_EN to get a ramped, attenuating mute instead of the default hard mute.
module i2s_audio_tx #(
  parameter int ATT_MAX = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] audio_in_left,
  input  logic [15:0] audio_in_right,
  input  logic        mute,
  output logic        audio_mclk,
  output logic        audio_sck,
  output logic        audio_lrck,
  output logic        audio_sdin,
  output logic        sample_tick
);

  logic [8:0]  cnt;
  logic [31:0] sr;
  logic        mute_q;
  logic        load;
  logic        sck_fall;
  logic        out_bit;
  logic [15:0] left_next;
  logic [15:0] right_next;

  if (ATT_MAX < 1 || ATT_MAX > 15) begin : g_att_range
    $error("i2s_audio_tx: ATT_MAX must be in 1..15");
  end

  assign load        = (cnt == 9'd511);
  assign sck_fall    = (cnt[3:0] == 4'hF);
  assign audio_mclk  = cnt[1];
  assign audio_sck   = cnt[3];
  assign audio_lrck  = cnt[8];

`ifdef SOFT_MUTE_EN
  localparam logic [3:0] ATT_TOP = 4'(ATT_MAX);

  logic [3:0] att;
  logic [3:0] att_next;

  // One attenuation step per frame; reaching the top of the ramp means true silence.
  always_comb begin
    att_next = att;
    if (mute) begin
      if (att < ATT_TOP) att_next = att + 4'd1;
    end else if (att != 4'd0) begin
      att_next = att - 4'd1;
    end
    left_next  = 16'($signed(audio_in_left)  >>> att_next);
    right_next = 16'($signed(audio_in_right) >>> att_next);
    if (att_next == ATT_TOP) begin
      left_next  = 16'h0000;
      right_next = 16'h0000;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) att <= ATT_TOP;
    else if (load) att <= att_next;
  end

  // A frame loaded fully attenuated holds only zeros; the gate makes that explicit at the pin.
  assign out_bit = sr[31] & ~(mute_q & (att == ATT_TOP));
`else
  assign left_next  = mute ? 16'h0000 : audio_in_left;
  assign right_next = mute ? 16'h0000 : audio_in_right;

  // A muted frame holds only zeros; the gate makes that explicit at the pin.
  assign out_bit = sr[31] & ~mute_q;
`endif

  // Frame load replaces the shift on the last SCK falling event of the frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= 9'd0;
      sr          <= 32'd0;
      audio_sdin  <= 1'b0;
      sample_tick <= 1'b0;
      mute_q      <= 1'b0;
    end else begin
      cnt         <= cnt + 9'd1;
      sample_tick <= load;
      if (load) begin
        audio_sdin <= out_bit;
        sr         <= {left_next, right_next};
        mute_q     <= mute;
      end else if (sck_fall) begin
        audio_sdin <= out_bit;
        sr         <= {sr[30:0], 1'b0};
      end
    end
  end

endmodule

// File: tb/tb_i2s_audio_tx.sv
// Self-checking bench for i2s_audio_tx: a slot-level frame model checked every cycle,
// plus directed frames whose serial words are reassembled and compared to literals.
module tb_i2s_audio_tx;

  localparam int ATT = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] audio_in_left  = 16'h0000;
  logic [15:0] audio_in_right = 16'h0000;
  logic        mute = 1'b0;
  logic        audio_mclk;
  logic        audio_sck;
  logic        audio_lrck;
  logic        audio_sdin;
  logic        sample_tick;

  int checks = 0;
  int errors = 0;

  i2s_audio_tx #(.ATT_MAX(ATT)) dut (
    .clk            (clk),
    .rst            (rst),
    .audio_in_left  (audio_in_left),
    .audio_in_right (audio_in_right),
    .mute           (mute),
    .audio_mclk     (audio_mclk),
    .audio_sck      (audio_sck),
    .audio_lrck     (audio_lrck),
    .audio_sdin     (audio_sdin),
    .sample_tick    (sample_tick)
  );

  always #5 clk = ~clk;

  // Model state: position in the frame, the words of the frame on the wire, and
  // the last bit of the previous right word, which opens each left half.
  int          mc = 0;
  logic [15:0] cur_l = 16'h0000;
  logic [15:0] cur_r = 16'h0000;
  logic        prev_r0 = 1'b0;
  logic        tick_exp = 1'b0;
`ifdef SOFT_MUTE_EN
  int          att = ATT;

  function automatic int nextAtt(input int a, input logic m);
    if (m) return (a < ATT) ? a + 1 : a;
    return (a > 0) ? a - 1 : 0;
  endfunction

  function automatic logic [15:0] scaled(input logic [15:0] x, input int a);
    logic signed [15:0] sx;
    sx = x;
    if (a >= ATT) return 16'h0000;
    return 16'(sx >>> a);
  endfunction
`endif

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mc       <= 0;
      cur_l    <= 16'h0000;
      cur_r    <= 16'h0000;
      prev_r0  <= 1'b0;
      tick_exp <= 1'b0;
`ifdef SOFT_MUTE_EN
      att      <= ATT;
`endif
    end else begin
      tick_exp <= (mc == 511);
      if (mc == 511) begin
        prev_r0 <= cur_r[0];
`ifdef SOFT_MUTE_EN
        att   <= nextAtt(att, mute);
        cur_l <= scaled(audio_in_left,  nextAtt(att, mute));
        cur_r <= scaled(audio_in_right, nextAtt(att, mute));
`else
        cur_l <= mute ? 16'h0000 : audio_in_left;
        cur_r <= mute ? 16'h0000 : audio_in_right;
`endif
      end
      mc <= (mc == 511) ? 0 : mc + 1;
    end
  end

  // Expected pins {mclk, sck, lrck, sdin, tick} at frame position c.
  function automatic logic [4:0] expectedPins(input int c);
    int   s;
    logic d;
    s = (c % 256) / 16;
    if (c < 256) d = (s == 0) ? prev_r0 : cur_l[16 - s];
    else         d = (s == 0) ? cur_l[0] : cur_r[16 - s];
    return {((c / 2) % 2) == 1, ((c / 8) % 2) == 1, c >= 256, d, tick_exp};
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if ({audio_mclk, audio_sck, audio_lrck, audio_sdin, sample_tick} !== expectedPins(mc)) begin
        errors++;
        $display("[TB] FAIL pins cnt=%0d got mclk/sck/lrck/sdin/tick=%b expected %b",
                 mc, {audio_mclk, audio_sck, audio_lrck, audio_sdin, sample_tick}, expectedPins(mc));
      end
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] l, input logic [15:0] r, input logic m);
    audio_in_left  = l;
    audio_in_right = r;
    mute           = m;
  endtask

  task automatic waitCnt(input int target);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (mc != target && n < 1100);
    if (mc != target) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_cnt got %0d expected %0d", mc, target);
    end
  endtask

  // Reassemble one frame from sdin at mid-slot (SCK high). r[0] arrives in the next
  // frame, so r comes back with bit 0 clear; s0 is this frame's left slot 0.
  task automatic captureFrame(output logic [15:0] l, output logic [15:0] r, output logic s0);
    int s;
    l  = 16'h0000;
    r  = 16'h0000;
    s0 = 1'b0;
    waitCnt(0);
    for (int i = 0; i < 512; i++) begin
      if (i > 0) @(negedge clk);
      if (i % 16 == 8) begin
        s = (i % 256) / 16;
        if (i < 256) begin
          if (s == 0) s0 = audio_sdin;
          else        l[16 - s] = audio_sdin;
        end else begin
          if (s == 0) l[0] = audio_sdin;
          else        r[16 - s] = audio_sdin;
        end
      end
    end
  endtask

  function automatic logic [15:0] pins16();
    return {11'b0, audio_mclk, audio_sck, audio_lrck, audio_sdin, sample_tick};
  endfunction

  logic [15:0] l_word;
  logic [15:0] r_word;
  logic        slot0;
  int          n;
`ifdef SOFT_MUTE_EN
  logic [15:0] ramp_up   [8];
  logic [15:0] ramp_down [8];
`endif

  initial begin
    rst = 1'b1;
    applyStimulus(16'h0000, 16'h0000, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("reset_pins", pins16(), 16'h0000);
    end

`ifdef SOFT_MUTE_EN
    ramp_up   = '{16'h0080, 16'h0100, 16'h0200, 16'h0400, 16'h0800, 16'h1000, 16'h2000, 16'h4000};
    ramp_down = '{16'h2000, 16'h1000, 16'h0800, 16'h0400, 16'h0200, 16'h0100, 16'h0080, 16'h0000};
    applyStimulus(16'h4000, 16'hC000, 1'b0);
    @(negedge clk);
    #2 rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      captureFrame(l_word, r_word, slot0);
      checkOutput($sformatf("ramp_up_%0d", k), l_word, ramp_up[k]);
      if (k == 0) checkOutput("first_right_neg", r_word, 16'hFF80);
    end
    applyStimulus(16'h4000, 16'hC000, 1'b1);
    for (int k = 0; k < 8; k++) begin
      captureFrame(l_word, r_word, slot0);
      checkOutput($sformatf("ramp_down_%0d", k), l_word, ramp_down[k]);
    end
`else
    applyStimulus(16'hA000, 16'h6000, 1'b0);
    @(negedge clk);
    #2 rst = 1'b0;

    captureFrame(l_word, r_word, slot0);
    checkOutput("f1_left", l_word, 16'hA000);
    checkOutput("f1_right_hi", r_word, 16'h6000);

    fork
      captureFrame(l_word, r_word, slot0);
      begin waitCnt(0); waitCnt(100); applyStimulus(16'h1234, 16'h1234, 1'b0); end
    join
    checkOutput("f2_left_held", l_word, 16'hA000);
    checkOutput("f2_right_held", r_word, 16'h6000);
    checkOutput("f2_slot0", {15'b0, slot0}, 16'h0000);

    fork
      captureFrame(l_word, r_word, slot0);
      begin waitCnt(0); waitCnt(100); applyStimulus(16'hB000, 16'hB000, 1'b0); end
    join
    checkOutput("f3_left_new", l_word, 16'h1234);
    checkOutput("f3_right_new", r_word, 16'h1234);

    fork
      captureFrame(l_word, r_word, slot0);
      begin waitCnt(0); waitCnt(300); applyStimulus(16'hB000, 16'hB000, 1'b1); end
    join
    checkOutput("mute_cur_left", l_word, 16'hB000);
    checkOutput("mute_cur_right", r_word, 16'hB000);

    fork
      captureFrame(l_word, r_word, slot0);
      begin waitCnt(0); waitCnt(100); applyStimulus(16'hB000, 16'hB000, 1'b0); end
    join
    checkOutput("muted_left", l_word, 16'h0000);
    checkOutput("muted_right", r_word, 16'h0000);

    fork
      captureFrame(l_word, r_word, slot0);
      begin waitCnt(0); waitCnt(100); applyStimulus(16'h5A5B, 16'hC3C5, 1'b0); end
    join
    checkOutput("unmute_left", l_word, 16'hB000);
    checkOutput("unmute_right", r_word, 16'hB000);

    captureFrame(l_word, r_word, slot0);
    checkOutput("odd_left", l_word, 16'h5A5B);
    checkOutput("odd_right_hi", r_word, 16'hC3C4);

    captureFrame(l_word, r_word, slot0);
    checkOutput("odd_right_lsb", {15'b0, slot0}, 16'h0001);
`endif

    n = 0;
    repeat (1024) begin
      @(negedge clk);
      if (sample_tick) n++;
    end
    checkOutput("tick_count", 16'(n), 16'd2);

    waitCnt(200);
    #2 rst = 1'b1;
    #1 checkOutput("rst_immediate", pins16(), 16'h0000);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("rst_hold", pins16(), 16'h0000);
    end
    #2 rst = 1'b0;

    n = 1;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (audio_lrck) break;
      n++;
    end
    checkOutput("lrck_low_len", 16'(n), 16'd256);
    n = 1;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (!audio_lrck) break;
      n++;
    end
    checkOutput("lrck_high_len", 16'(n), 16'd256);

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
